// File: rtl/id_stage_if.sv
// Fetch-to-decode and decode-to-execute channels of the RV32I decode stage.
// Handshake: a beat moves on a rising edge where valid and ready are both high;
// the master holds valid and the payload stable until that edge.
interface id_fetch_if #(parameter int XLEN = 32);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [31:0]     inst;

  modport master (output valid, pc, inst, input ready);
  modport slave  (input valid, pc, inst, output ready);
endinterface

interface id_ex_if #(parameter int XLEN = 32);
  logic            valid;
  logic            ready;
  logic [6:0]      op;
  logic [2:0]      f3;
  logic            alt;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] imm;
  logic [4:0]      wa;
  logic            we;
  logic            illegal;

  modport master (output valid, op, f3, alt, a, b, imm, wa, we, illegal, input ready);
  modport slave  (input valid, op, f3, alt, a, b, imm, wa, we, illegal, output ready);
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: register read, forwarding, load-use interlock, ID/EX register.
// Define ID_BRANCH_EN to resolve jumps/branches here and redirect fetch.
module id_stage #(
  parameter int XLEN = 32,
  parameter int NFWD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  id_fetch_if.slave            fetch,
  id_ex_if.master              ex,
  output logic [4:0]           rf_ra1,
  output logic [4:0]           rf_ra2,
  input  logic [XLEN-1:0]      rf_rd1,
  input  logic [XLEN-1:0]      rf_rd2,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD-1:0]      fwd_ld,
  input  logic [5*NFWD-1:0]    fwd_wa,
  input  logic [XLEN*NFWD-1:0] fwd_wd,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 dbg_kill
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0]     inst;
  logic [6:0]      op;
  logic [2:0]      f3;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] v1, v2, a_val, b_val;
  logic            ld1, ld2, use1, use2, legal, stall, accept, we_val, kill;

  assign inst   = fetch.inst;
  assign op     = inst[6:0];
  assign f3     = inst[14:12];
  assign rf_ra1 = inst[19:15];
  assign rf_ra2 = inst[24:20];
  assign imm    = XLEN'($signed(imm32));

  always_comb begin
    imm32 = {{20{inst[31]}}, inst[31:20]};
    case (op)
      OP_STORE:         imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm32 = {inst[31:12], 12'b0};
      OP_JAL:           imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      OP_IMM:           if (f3 == 3'b001 || f3 == 3'b101) imm32 = {27'b0, inst[24:20]};
      default:          ;
    endcase
  end

  // Descending scan so the lowest-index (youngest) matching source wins.
  always_comb begin
    v1 = rf_rd1;
    v2 = rf_rd2;
    ld1 = 1'b0;
    ld2 = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && fwd_wa[5*i +: 5] == rf_ra1) begin
        v1  = fwd_wd[XLEN*i +: XLEN];
        ld1 = fwd_ld[i];
      end
      if (fwd_we[i] && fwd_wa[5*i +: 5] == rf_ra2) begin
        v2  = fwd_wd[XLEN*i +: XLEN];
        ld2 = fwd_ld[i];
      end
    end
    if (rf_ra1 == 5'd0) begin
      v1  = '0;
      ld1 = 1'b0;
    end
    if (rf_ra2 == 5'd0) begin
      v2  = '0;
      ld2 = 1'b0;
    end
  end

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
      OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    use1 = (op == OP_IMM) || (op == OP_OP) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JALR);
    use2 = (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
    a_val = v1;
    if (op == OP_LUI) a_val = '0;
    else if (op == OP_AUIPC || op == OP_JAL || op == OP_JALR) a_val = fetch.pc;
    b_val = imm;
    if (use2) b_val = v2;
    else if (op == OP_JAL || op == OP_JALR) b_val = XLEN'(32'd4);
    we_val = legal && (op != OP_BRANCH) && (op != OP_STORE) && (inst[11:7] != 5'd0);
  end

  assign stall       = (use1 && ld1) || (use2 && ld2);
  assign fetch.ready = !rst && !stall && (!ex.valid || ex.ready);
  assign accept      = fetch.valid && fetch.ready;
  assign dbg_kill    = kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex.valid   <= 1'b0;
      ex.op      <= '0;
      ex.f3      <= '0;
      ex.alt     <= 1'b0;
      ex.a       <= '0;
      ex.b       <= '0;
      ex.imm     <= '0;
      ex.wa      <= '0;
      ex.we      <= 1'b0;
      ex.illegal <= 1'b0;
    end else if (flush) begin
      ex.valid <= 1'b0;
    end else if (accept && !kill) begin
      ex.valid   <= 1'b1;
      ex.op      <= op;
      ex.f3      <= f3;
      ex.alt     <= inst[30];
      ex.a       <= a_val;
      ex.b       <= b_val;
      ex.imm     <= imm;
      ex.wa      <= inst[11:7];
      ex.we      <= we_val;
      ex.illegal <= !legal;
    end else if (accept || ex.ready) begin
      // A killed beat or an idle consumed cycle leaves a bubble.
      ex.valid <= 1'b0;
    end
  end

`ifdef ID_BRANCH_EN
  logic            taken;
  logic [XLEN-1:0] target;

  always_comb begin
    taken = 1'b0;
    if (op == OP_JAL || op == OP_JALR) begin
      taken = 1'b1;
    end else if (op == OP_BRANCH) begin
      case (f3)
        3'b000:  taken = (v1 == v2);
        3'b001:  taken = (v1 != v2);
        3'b100:  taken = ($signed(v1) < $signed(v2));
        3'b101:  taken = ($signed(v1) >= $signed(v2));
        3'b110:  taken = (v1 < v2);
        3'b111:  taken = (v1 >= v2);
        default: taken = 1'b0;
      endcase
    end
    target = (op == OP_JALR) ? ((v1 + imm) & ~XLEN'(1)) : (fetch.pc + imm);
  end

  // The beat after a redirect is the wrong-path fall-through; the kill flag drops it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      redirect_valid <= 1'b0;
      kill           <= 1'b0;
      if (rst) redirect_pc <= '0;
    end else begin
      redirect_valid <= 1'b0;
      if (accept) begin
        if (kill) begin
          kill <= 1'b0;
        end else if (taken) begin
          redirect_valid <= 1'b1;
          redirect_pc    <= target;
          kill           <= 1'b1;
        end
      end
    end
  end
`else
  assign redirect_valid = 1'b0;
  assign redirect_pc    = '0;
  assign kill           = 1'b0;
`endif
endmodule
